tinyqv_mem_arbiter: RTL and testbench

Shares the single QSPI memory controller port between the TinyQV CPU's instruction-fetch stream and its data load/store port. Sits between `tinyqv_cpu` and the memory controller. Sequences instruction streams (start, run, stop) and preempts them for data transactions, data having priority.

---
 rtl/tinyqv_mem_arbiter_pkg.sv | 23 ++
 rtl/tinyqv_mem_arbiter_if.sv | 56 +++++
 rtl/tinyqv_mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_tinyqv_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyqv_mem_arbiter_pkg.sv
// Shared types and constants for the TinyQV memory arbiter.
package tinyqv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  // Access-width encoding shared by the CPU data port and the controller.
  localparam logic [1:0] OP_NONE = 2'b11;
  localparam logic [1:0] OP_8    = 2'b00;
  localparam logic [1:0] OP_16   = 2'b01;
  localparam logic [1:0] OP_32   = 2'b10;

  localparam int MIN_FETCH_DEFAULT = 2;

  function automatic logic op_active(input logic [1:0] op);
    return (op != OP_NONE);
  endfunction

endpackage

// File: rtl/tinyqv_mem_arbiter_if.sv
// CPU-side and controller-side bundles of the TinyQV memory arbiter.
interface tinyqv_mem_arbiter_cpu_if;
  logic [23:1] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started;
  logic        instr_fetch_stopped;
  logic [15:0] instr_data_in;
  logic        instr_ready;
  logic [23:0] data_addr;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_continue;
  logic        data_ready;
  logic [31:0] data_in;

  modport master (
    output instr_addr, instr_fetch_restart, instr_fetch_stall,
    output data_addr, data_write_n, data_read_n, data_out, data_continue,
    input  instr_fetch_started, instr_fetch_stopped, instr_data_in, instr_ready,
    input  data_ready, data_in
  );

  modport slave (
    input  instr_addr, instr_fetch_restart, instr_fetch_stall,
    input  data_addr, data_write_n, data_read_n, data_out, data_continue,
    output instr_fetch_started, instr_fetch_stopped, instr_data_in, instr_ready,
    output data_ready, data_in
  );
endinterface

interface tinyqv_mem_arbiter_mem_if;
  logic [23:0] mem_addr;
  logic [1:0]  mem_read_n;
  logic [1:0]  mem_write_n;
  logic [31:0] mem_data_out;
  logic        mem_continue;
  logic        mem_start;
  logic        mem_stop;
  logic        mem_busy;
  logic        mem_data_ready;
  logic [31:0] mem_data_in;

  modport master (
    output mem_addr, mem_read_n, mem_write_n, mem_data_out, mem_continue,
    output mem_start, mem_stop,
    input  mem_busy, mem_data_ready, mem_data_in
  );

  modport slave (
    input  mem_addr, mem_read_n, mem_write_n, mem_data_out, mem_continue,
    input  mem_start, mem_stop,
    output mem_busy, mem_data_ready, mem_data_in
  );
endinterface

// File: rtl/tinyqv_mem_arbiter.sv
// Shares the QSPI controller port between TinyQV instruction fetch and data accesses.
// Define TINYQV_ARB_STARVE_GUARD_EN to guarantee MIN_FETCH halfwords per stream before data preemption.
module tinyqv_mem_arbiter
  import tinyqv_arb_pkg::*;
#(
  parameter int MIN_FETCH = MIN_FETCH_DEFAULT
) (
  input logic                       clk,
  input logic                       rst,
  tinyqv_mem_arbiter_cpu_if.slave   cpu,
  tinyqv_mem_arbiter_mem_if.master  mem
);

  arb_state_e  state_r;
  logic [23:0] mem_addr_r;
  logic [1:0]  mem_read_n_r;
  logic [1:0]  mem_write_n_r;
  logic [31:0] mem_data_out_r;
  logic        mem_continue_r;
  logic        mem_start_r;
  logic        started_r;
  logic        cont_pend_r;

  logic        data_req_s;
  logic        fetch_req_s;
  logic        preempt_s;
  logic        stop_s;
  logic        abort_s;
  logic        instr_ready_s;
  logic [15:0] instr_data_s;
  logic        data_ready_s;
  logic [31:0] data_in_s;

  // Request decode shared by launch and preemption
  always_comb begin
    data_req_s  = op_active(cpu.data_read_n) || op_active(cpu.data_write_n);
    fetch_req_s = cpu.instr_fetch_restart && !cpu.instr_fetch_stall;
  end

`ifdef TINYQV_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (MIN_FETCH < 1) ? 1 : $clog2(MIN_FETCH + 1);
  logic [CNT_W-1:0] fetch_cnt_r;

  // Saturating count of halfwords delivered in the current stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_r <= '0;
    end else if (state_r != INSTR) begin
      fetch_cnt_r <= '0;
    end else if (instr_ready_s && (fetch_cnt_r < CNT_W'(MIN_FETCH))) begin
      fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
    end
  end

  assign preempt_s = data_req_s && (fetch_cnt_r >= CNT_W'(MIN_FETCH));
`else
  localparam int unused_min_fetch = MIN_FETCH;
  assign preempt_s = data_req_s;
`endif

  // Stop conditions are combinational so a racing halfword is dropped in the same cycle
  always_comb begin
    stop_s  = (state_r == INSTR) &&
              (cpu.instr_fetch_stall || cpu.instr_fetch_restart || preempt_s);
    abort_s = (state_r == DATA) && cont_pend_r && !data_req_s;
  end

  // Zero-latency return path from the controller to the owning requester
  always_comb begin
    instr_ready_s = 1'b0;
    instr_data_s  = 16'h0000;
    data_ready_s  = 1'b0;
    data_in_s     = 32'h0000_0000;
    case (state_r)
      INSTR: begin
        instr_ready_s = mem.mem_data_ready && !stop_s;
        instr_data_s  = mem.mem_data_in[15:0];
      end
      DATA: begin
        data_ready_s = mem.mem_data_ready;
        data_in_s    = mem.mem_data_in;
      end
      default: begin
        instr_ready_s = 1'b0;
      end
    endcase
  end

  // Arbitration state and registered controller command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      mem_addr_r     <= 24'h00_0000;
      mem_read_n_r   <= OP_NONE;
      mem_write_n_r  <= OP_NONE;
      mem_data_out_r <= 32'h0000_0000;
      mem_continue_r <= 1'b0;
      mem_start_r    <= 1'b0;
      started_r      <= 1'b0;
      cont_pend_r    <= 1'b0;
    end else begin
      mem_start_r <= 1'b0;
      started_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (data_req_s) begin
            mem_addr_r     <= cpu.data_addr;
            mem_read_n_r   <= cpu.data_read_n;
            mem_write_n_r  <= cpu.data_write_n;
            mem_data_out_r <= cpu.data_out;
            mem_continue_r <= cpu.data_continue;
            mem_start_r    <= 1'b1;
            cont_pend_r    <= 1'b0;
            state_r        <= DATA;
          end else if (fetch_req_s) begin
            mem_addr_r     <= {cpu.instr_addr, 1'b0};
            mem_read_n_r   <= OP_16;
            mem_write_n_r  <= OP_NONE;
            mem_continue_r <= 1'b1;
            mem_start_r    <= 1'b1;
            started_r      <= 1'b1;
            state_r        <= INSTR;
          end
        end
        INSTR: begin
          if (stop_s) begin
            mem_read_n_r   <= OP_NONE;
            mem_write_n_r  <= OP_NONE;
            mem_continue_r <= 1'b0;
            state_r        <= DRAIN;
          end
        end
        DATA: begin
          if (abort_s) begin
            mem_read_n_r   <= OP_NONE;
            mem_write_n_r  <= OP_NONE;
            mem_continue_r <= 1'b0;
            cont_pend_r    <= 1'b0;
            state_r        <= DRAIN;
          end else if (cont_pend_r) begin
            // CPU presents its follow-on access the cycle after data_ready
            mem_addr_r     <= cpu.data_addr;
            mem_read_n_r   <= cpu.data_read_n;
            mem_write_n_r  <= cpu.data_write_n;
            mem_data_out_r <= cpu.data_out;
            mem_continue_r <= cpu.data_continue;
            cont_pend_r    <= 1'b0;
          end else if (mem.mem_data_ready) begin
            if (mem_continue_r) begin
              cont_pend_r <= 1'b1;
            end else begin
              mem_read_n_r  <= OP_NONE;
              mem_write_n_r <= OP_NONE;
              state_r       <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!mem.mem_busy) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_addr             = mem_addr_r;
  assign mem.mem_read_n           = mem_read_n_r;
  assign mem.mem_write_n          = mem_write_n_r;
  assign mem.mem_data_out         = mem_data_out_r;
  assign mem.mem_continue         = mem_continue_r;
  assign mem.mem_start            = mem_start_r;
  assign mem.mem_stop             = stop_s || abort_s;
  assign cpu.instr_fetch_started  = started_r;
  assign cpu.instr_fetch_stopped  = stop_s;
  assign cpu.instr_ready          = instr_ready_s;
  assign cpu.instr_data_in        = instr_data_s;
  assign cpu.data_ready           = data_ready_s;
  assign cpu.data_in              = data_in_s;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed self-checking bench for tinyqv_mem_arbiter; honours TINYQV_ARB_STARVE_GUARD_EN.
module tb_tinyqv_mem_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  tinyqv_mem_arbiter_cpu_if cif ();
  tinyqv_mem_arbiter_mem_if mif ();

  tinyqv_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .cpu (cif),
    .mem (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drain_to_idle();
    mif.mem_data_ready = 1'b0;
    mif.mem_busy       = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    cif.instr_addr = 23'h000000;
    cif.instr_fetch_restart = 1'b0;
    cif.instr_fetch_stall = 1'b0;
    cif.data_addr = 24'h000000;
    cif.data_write_n = 2'b11;
    cif.data_read_n = 2'b11;
    cif.data_out = 32'h0;
    cif.data_continue = 1'b0;
    mif.mem_busy = 1'b0;
    mif.mem_data_ready = 1'b0;
    mif.mem_data_in = 32'h0;
    tick();
    tick();
    chk("rst_read_n", 32'(mif.mem_read_n), 32'h3);
    chk("rst_write_n", 32'(mif.mem_write_n), 32'h3);
    chk("rst_start", 32'(mif.mem_start), 32'h0);
    chk("rst_stop", 32'(mif.mem_stop), 32'h0);
    chk("rst_cont", 32'(mif.mem_continue), 32'h0);
    chk("rst_addr", 32'(mif.mem_addr), 32'h0);
    chk("rst_dout", mif.mem_data_out, 32'h0);
    chk("rst_flags", {28'h0, cif.instr_fetch_started, cif.instr_fetch_stopped,
                      cif.instr_ready, cif.data_ready}, 32'h0);
    rst = 1'b0;
    tick();

    // Fetch-only stream of four halfwords
    cif.instr_addr = 23'h000100;
    cif.instr_fetch_restart = 1'b1;
    #1 chk("f_no_early_start", 32'(mif.mem_start), 32'h0);
    tick();
    chk("f_start", 32'(mif.mem_start), 32'h1);
    chk("f_started", 32'(cif.instr_fetch_started), 32'h1);
    chk("f_addr", 32'(mif.mem_addr), 32'h000200);
    chk("f_read_n", 32'(mif.mem_read_n), 32'h1);
    chk("f_cont", 32'(mif.mem_continue), 32'h1);
    cif.instr_fetch_restart = 1'b0;
    mif.mem_busy = 1'b1;
    tick();
    chk("f_start_pulse", 32'(mif.mem_start), 32'h0);
    for (int i = 0; i < 4; i++) begin
      mif.mem_data_ready = 1'b1;
      mif.mem_data_in = 32'hABCD_0000 | (32'h1111 * (i + 1));
      #1;
      chk("f_ready", 32'(cif.instr_ready), 32'h1);
      chk("f_hw", 32'(cif.instr_data_in), 32'h1111 * (i + 1));
      chk("f_no_dready", 32'(cif.data_ready), 32'h0);
      tick();
      mif.mem_data_ready = 1'b0;
      #1 chk("f_ready_gap", 32'(cif.instr_ready), 32'h0);
      tick();
    end
    cif.instr_fetch_stall = 1'b1;
    #1;
    chk("f_stopped", 32'(cif.instr_fetch_stopped), 32'h1);
    chk("f_mem_stop", 32'(mif.mem_stop), 32'h1);
    tick();
    cif.instr_fetch_stall = 1'b0;
    chk("f_drain_read_n", 32'(mif.mem_read_n), 32'h3);
    chk("f_stop_pulse", 32'(cif.instr_fetch_stopped), 32'h0);
    drain_to_idle();

    // Data load preempts a running fetch after one halfword
    cif.instr_addr = 23'h000400;
    cif.instr_fetch_restart = 1'b1;
    tick();
    chk("p_addr", 32'(mif.mem_addr), 32'h000800);
    cif.instr_fetch_restart = 1'b0;
    mif.mem_busy = 1'b1;
    mif.mem_data_ready = 1'b1;
    mif.mem_data_in = 32'h0000_1234;
    #1 chk("p_hw1", 32'(cif.instr_data_in), 32'h1234);
    tick();
    mif.mem_data_ready = 1'b0;
    cif.data_addr = 24'h001000;
    cif.data_read_n = 2'b10;
`ifdef TINYQV_ARB_STARVE_GUARD_EN
    #1 chk("g_no_stop_early", 32'(mif.mem_stop), 32'h0);
    mif.mem_data_ready = 1'b1;
    mif.mem_data_in = 32'h0000_5678;
    #1;
    chk("g_hw2_ready", 32'(cif.instr_ready), 32'h1);
    chk("g_no_stop_hw2", 32'(cif.instr_fetch_stopped), 32'h0);
    tick();
    mif.mem_data_ready = 1'b0;
`endif
    #1;
    chk("p_stop", 32'(mif.mem_stop), 32'h1);
    chk("p_stopped", 32'(cif.instr_fetch_stopped), 32'h1);
    tick();
    chk("p_drain_read_n", 32'(mif.mem_read_n), 32'h3);
    tick();
    chk("p_wait_busy", 32'(mif.mem_start), 32'h0);
    mif.mem_busy = 1'b0;
    tick();
    chk("p_idle_dwell", 32'(mif.mem_start), 32'h0);
    tick();
    chk("p_load_start", 32'(mif.mem_start), 32'h1);
    chk("p_load_read_n", 32'(mif.mem_read_n), 32'h2);
    chk("p_load_addr", 32'(mif.mem_addr), 32'h001000);
    mif.mem_busy = 1'b1;
    mif.mem_data_ready = 1'b1;
    mif.mem_data_in = 32'hDEAD_BEEF;
    #1;
    chk("p_dready", 32'(cif.data_ready), 32'h1);
    chk("p_data_in", cif.data_in, 32'hDEAD_BEEF);
    chk("p_no_iready", 32'(cif.instr_ready), 32'h0);
    tick();
    cif.data_read_n = 2'b11;
    chk("p_done_read_n", 32'(mif.mem_read_n), 32'h3);
    drain_to_idle();

    // Stall racing a returned halfword
    cif.instr_addr = 23'h000010;
    cif.instr_fetch_restart = 1'b1;
    tick();
    cif.instr_fetch_restart = 1'b0;
    mif.mem_busy = 1'b1;
    cif.instr_fetch_stall = 1'b1;
    mif.mem_data_ready = 1'b1;
    mif.mem_data_in = 32'h0000_5555;
    #1;
    chk("s_ready_dropped", 32'(cif.instr_ready), 32'h0);
    chk("s_stopped", 32'(cif.instr_fetch_stopped), 32'h1);
    tick();
    cif.instr_fetch_stall = 1'b0;
    #1 chk("s_no_late_ready", 32'(cif.instr_ready), 32'h0);
    drain_to_idle();

    // Simultaneous store and restart: data wins
    cif.data_write_n = 2'b01;
    cif.data_addr = 24'h000010;
    cif.data_out = 32'h0000_BEEF;
    cif.instr_addr = 23'h000300;
    cif.instr_fetch_restart = 1'b1;
    tick();
    chk("c_write_n", 32'(mif.mem_write_n), 32'h1);
    chk("c_read_n", 32'(mif.mem_read_n), 32'h3);
    chk("c_addr", 32'(mif.mem_addr), 32'h000010);
    chk("c_dout", mif.mem_data_out, 32'h0000_BEEF);
    chk("c_no_started", 32'(cif.instr_fetch_started), 32'h0);
    mif.mem_busy = 1'b1;
    mif.mem_data_ready = 1'b1;
    #1 chk("c_dready", 32'(cif.data_ready), 32'h1);
    tick();
    cif.data_write_n = 2'b11;
    mif.mem_data_ready = 1'b0;
    chk("c_drain_write_n", 32'(mif.mem_write_n), 32'h3);
    mif.mem_busy = 1'b0;
    tick();
    chk("c_idle_no_start", 32'(mif.mem_start), 32'h0);
    tick();
    chk("c_fetch_started", 32'(cif.instr_fetch_started), 32'h1);
    chk("c_fetch_addr", 32'(mif.mem_addr), 32'h000600);
    cif.instr_fetch_restart = 1'b0;
    mif.mem_busy = 1'b1;
    cif.instr_fetch_stall = 1'b1;
    tick();
    cif.instr_fetch_stall = 1'b0;
    drain_to_idle();

    // Continued 32-bit store pair under a single mem_start
    cif.data_write_n = 2'b10;
    cif.data_addr = 24'h000100;
    cif.data_out = 32'h1122_3344;
    cif.data_continue = 1'b1;
    tick();
    chk("k_start", 32'(mif.mem_start), 32'h1);
    chk("k_cont", 32'(mif.mem_continue), 32'h1);
    mif.mem_busy = 1'b1;
    tick();
    mif.mem_data_ready = 1'b1;
    #1 chk("k_dready1", 32'(cif.data_ready), 32'h1);
    tick();
    mif.mem_data_ready = 1'b0;
    cif.data_addr = 24'h000104;
    cif.data_out = 32'h5566_7788;
    cif.data_continue = 1'b0;
    tick();
    chk("k_addr2", 32'(mif.mem_addr), 32'h000104);
    chk("k_dout2", mif.mem_data_out, 32'h5566_7788);
    chk("k_cont2", 32'(mif.mem_continue), 32'h0);
    chk("k_single_start", 32'(mif.mem_start), 32'h0);
    chk("k_write_n2", 32'(mif.mem_write_n), 32'h2);
    mif.mem_data_ready = 1'b1;
    #1 chk("k_dready2", 32'(cif.data_ready), 32'h1);
    tick();
    cif.data_write_n = 2'b11;
    mif.mem_data_ready = 1'b0;
    chk("k_drain_write_n", 32'(mif.mem_write_n), 32'h3);
    #1 chk("k_no_dready", 32'(cif.data_ready), 32'h0);
    drain_to_idle();

    // Async reset in the middle of a load
    cif.data_read_n = 2'b00;
    cif.data_addr = 24'h000ABC;
    tick();
    chk("r_read_n", 32'(mif.mem_read_n), 32'h0);
    mif.mem_busy = 1'b1;
    mif.mem_data_ready = 1'b1;
    mif.mem_data_in = 32'hCAFE_F00D;
    #1 chk("r_dready", 32'(cif.data_ready), 32'h1);
    rst = 1'b1;
    #1;
    chk("r_async_read_n", 32'(mif.mem_read_n), 32'h3);
    chk("r_async_addr", 32'(mif.mem_addr), 32'h0);
    chk("r_async_dready", 32'(cif.data_ready), 32'h0);
    chk("r_async_data_in", cif.data_in, 32'h0);
    chk("r_no_stop", {30'h0, mif.mem_stop, cif.instr_fetch_stopped}, 32'h0);
    cif.data_read_n = 2'b11;
    mif.mem_data_ready = 1'b0;
    mif.mem_busy = 1'b0;
    tick();
    rst = 1'b0;
    cif.data_read_n = 2'b01;
    cif.data_addr = 24'h000222;
    tick();
    chk("r_relaunch_start", 32'(mif.mem_start), 32'h1);
    chk("r_relaunch_read_n", 32'(mif.mem_read_n), 32'h1);
    chk("r_relaunch_addr", 32'(mif.mem_addr), 32'h000222);
    mif.mem_busy = 1'b1;
    mif.mem_data_ready = 1'b1;
    mif.mem_data_in = 32'h0000_9ABC;
    #1 chk("r_relaunch_data", cif.data_in, 32'h0000_9ABC);
    tick();
    cif.data_read_n = 2'b11;
    drain_to_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
